uart_tx_arbiter: RTL

- Shares the single uart_tx transmitter between N_REQ byte producers, such as a status reporter, debug dump or command echo.
- Each requester uses a valid/ready handshake.
- The arbiter picks round-robin, owns uart_tx for exactly one frame, and waits for its done pulse.
- It enforces an idle gap between frames and recovers from a stuck transmitter with a watchdog.
- Sits between the producer logic and uart_tx; it never touches the uart_tx reset.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, bit timing, default frame watchdog
// and the arbiter state encoding.
package uart_pkg;

  localparam int DATA_W       = 8;
  localparam int CLK_HZ       = 100_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int FRAME_BITS   = 10;

  // Two full frames of slack, rounded up to a multiple of 5000 clocks.
  localparam int TIMEOUT_CYCLES =
    ((2 * FRAME_BITS * CLKS_PER_BIT + 4999) / 5000) * 5000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: returns the first set request at or after ptr_i,
// wrapping modulo N, plus a flag saying whether any request is set.
module uart_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_o
);

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx     = IDX_W'((int'(ptr_i) + k) % N);
      grant_o = req_i[idx] ? idx : grant_o;
      any_o   = any_o | req_i[idx];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte producers. Round-robin grant, one
// frame per grant, enforced idle gap, watchdog on a stuck transmitter.
module uart_tx_arbiter #(
  parameter int  N_REQ          = 4,
  parameter int  DATA_W         = uart_pkg::DATA_W,
  parameter int  GAP_CYCLES     = 2,
  parameter int  TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES,
  parameter int  TO_W           = 16,
  localparam int ID_W           = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ID_W-1:0]         grant_id,
  output logic [DATA_W-1:0]       tx_byte,
  output logic                    tx_enable,
  input  logic                    tx_done,
  output logic                    busy,
  output logic                    timeout_err
);

  import uart_pkg::*;

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [ID_W-1:0]   pick_s;
  logic              any_s;

  uart_rr_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_s),
    .any_o   (any_s)
  );

  // Next state and next registered outputs; outputs follow the next state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    byte_d  = byte_q;
    ready_d = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d         = SEND;
          gid_d           = pick_s;
          byte_d          = req_data[int'(pick_s) * DATA_W +: DATA_W];
          ptr_d           = (pick_s == ID_W'(N_REQ - 1)) ? '0 : pick_s + ID_W'(1);
          cnt_d           = '0;
          ready_d[pick_s] = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (tx_done) begin
          // A done landing on the watchdog cycle still counts as a good frame.
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == TO_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    en_d   = (state_d == SEND);
    busy_d = (state_d != IDLE);
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= '0;
      gid_q   <= '0;
      byte_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      gid_q   <= gid_d;
      byte_q  <= byte_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign req_ready   = ready_q;
  assign grant_id    = gid_q;
  assign tx_byte     = byte_q;
  assign tx_enable   = en_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule
